// File: rtl/stream_demux.sv
// stream_demux: one-to-N stream demultiplexer with a one-entry register slice
// per output channel. A word is steered to channel in_sel, or to every
// channel at once when in_bcast is set. Each channel drains independently,
// so a stalled channel only blocks words that would have to land on it.
module stream_demux #(
  parameter int data_bits = 1,
  parameter int sel_bits  = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [data_bits-1:0]                    in_data,
  input  logic [sel_bits-1:0]                     in_sel,
  input  logic                                    in_bcast,
  output logic [(2**sel_bits)-1:0]                out_valid,
  input  logic [(2**sel_bits)-1:0]                out_ready,
  output logic [(2**sel_bits)-1:0][data_bits-1:0] out_data,
  output logic                                    busy
);

  localparam int n_chan = 2**sel_bits;

  logic [n_chan-1:0] can_take;
  logic [n_chan-1:0] load;

  // A channel can accept a word if it is empty or is being drained this cycle
  always_comb begin
    can_take = '0;
    for (int i = 0; i < n_chan; i++) begin
      can_take[i] = !out_valid[i] || out_ready[i];
    end
  end

  // Broadcast needs every channel free so that no channel gets a partial copy
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) begin
      in_ready = &can_take;
    end else begin
      in_ready = can_take[in_sel];
    end
  end

  // Channels written by this cycle's input transfer
  always_comb begin
    load = '0;
    for (int i = 0; i < n_chan; i++) begin
      load[i] = in_valid && in_ready && (in_bcast || (in_sel == sel_bits'(i)));
    end
  end

  // Per-channel slice: a load wins over a drain so drain+refill stays full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < n_chan; i++) begin
        if (load[i]) begin
          out_valid[i] <= 1'b1;
          out_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = |out_valid;

endmodule
